// File: rtl/multicycle_controller.sv
// multicycle_controller
// Multi-cycle sequencer for the 16-bit CPU datapath. Each instruction is stepped through
// FETCH / DECODE / EXEC / MEM / WB, and both memories may stall the sequence.
//
// Parameters:
//   MEM_TIMEOUT  max cycles spent waiting on a memory ready before entering FAULT (1..255)
//   CNT_WIDTH    width of the performance counters (only used with CTRL_PERF_CNT_EN)
//
// Ports:
//   Clock, Reset_n       rising-edge clock, asynchronous active-low reset
//   opcode               IR[15:13] from the datapath
//   Zero                 ALU zero flag (BEQ decision)
//   imem_ready           instruction word valid this cycle
//   dmem_ready           data read/write completes this cycle
//   resume               leave HALT (ignored in every other state)
//   imem_req             instruction fetch request
//   IRWrite, PCWrite     instruction register / PC write strobes
//   RegDst .. ALUSrc     datapath controls; Branch also selects the branch target as PC source
//   ALUOp                00 add, 01 sub, 10 funct-decoded
//   halted, fault        controller is in HALT / FAULT
//
// Optional feature, enabled by defining CTRL_PERF_CNT_EN:
//   cycle_cnt            cycles spent outside IDLE/HALT/FAULT, wraps
//   instr_cnt            retired instructions (exit to FETCH from EXEC, MEM or WB), wraps
//
// Outputs are decoded combinationally from the registered state plus opcode, Zero and the
// memory readies, so every control is stable for the whole state and drops to 0 as soon as
// Reset_n is asserted.

module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [2:0] opcode,
    input  logic       Zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       resume,
    output logic       imem_req,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegDst,
    output logic       Branch,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       MemToReg,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       halted,
    output logic       fault
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
`endif
);

    // Reject out-of-range configurations at elaboration.
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_WIDTH < 1) begin : g_bad_param
        $error("multicycle_controller: MEM_TIMEOUT must be 1..255 and CNT_WIDTH >= 1");
    end

    localparam logic [2:0] OpRtype = 3'b000;
    localparam logic [2:0] OpAddi  = 3'b001;
    localparam logic [2:0] OpLw    = 3'b010;
    localparam logic [2:0] OpSw    = 3'b011;
    localparam logic [2:0] OpBeq   = 3'b100;
    localparam logic [2:0] OpAndi  = 3'b101;
    localparam logic [2:0] OpOri   = 3'b110;
    localparam logic [2:0] OpHalt  = 3'b111;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt,
        StFault
    } state_t;

    state_t     state_q;
    logic [7:0] wait_q;
    logic       timeout;

    // Ready arriving in the last allowed cycle still wins over the timeout.
    assign timeout = (wait_q == WaitLast);

`ifdef CTRL_PERF_CNT_EN
    logic retire;
    logic active;

    assign active = (state_q != StIdle) && (state_q != StHalt) && (state_q != StFault);
    assign retire = ((state_q == StExec) && ((opcode == OpBeq) || (opcode == OpHalt))) ||
                    ((state_q == StMem) && dmem_ready && (opcode != OpLw)) ||
                    (state_q == StWb);
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            wait_q  <= '0;
`ifdef CTRL_PERF_CNT_EN
            cycle_cnt <= '0;
            instr_cnt <= '0;
`endif
        end else begin
            // The wait counter only survives a cycle in which a memory stall keeps the state.
            wait_q <= '0;
            unique case (state_q)
                StIdle: state_q <= StFetch;
                StFetch: begin
                    if (imem_ready) begin
                        state_q <= StDecode;
                    end else if (timeout) begin
                        state_q <= StFault;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StDecode: state_q <= (opcode == OpHalt) ? StHalt : StExec;
                StExec: begin
                    unique case (opcode)
                        OpLw, OpSw:     state_q <= StMem;
                        OpBeq, OpHalt:  state_q <= StFetch;
                        default:        state_q <= StWb;
                    endcase
                end
                StMem: begin
                    if (dmem_ready) begin
                        state_q <= (opcode == OpLw) ? StWb : StFetch;
                    end else if (timeout) begin
                        state_q <= StFault;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StWb:    state_q <= StFetch;
                StHalt:  if (resume) state_q <= StFetch;
                StFault: state_q <= StFault;
                default: state_q <= StFault;
            endcase
`ifdef CTRL_PERF_CNT_EN
            if (active) cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instr_cnt <= instr_cnt + 1'b1;
`endif
        end
    end

    always_comb begin
        imem_req = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegDst   = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = AluAdd;
        halted   = 1'b0;
        fault    = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                IRWrite  = imem_ready;
                PCWrite  = imem_ready;
            end
            StExec: begin
                unique case (opcode)
                    OpRtype: begin
                        ALUOp  = AluFunct;
                        RegDst = 1'b1;
                    end
                    OpAddi, OpLw, OpSw: begin
                        ALUSrc = 1'b1;
                        ALUOp  = AluAdd;
                    end
                    OpAndi, OpOri: begin
                        ALUSrc = 1'b1;
                        ALUOp  = AluFunct;
                    end
                    OpBeq: begin
                        ALUOp   = AluSub;
                        Branch  = 1'b1;
                        PCWrite = Zero;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                // Only one of the two can decode, so they are never both high.
                MemRead  = (opcode == OpLw);
                MemWrite = (opcode == OpSw);
            end
            StWb: begin
                RegWrite = 1'b1;
                MemToReg = (opcode == OpLw);
                RegDst   = (opcode == OpRtype);
            end
            StHalt:  halted = 1'b1;
            StFault: fault  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the 16-bit CPU datapath; replaces single-cycle combinational control.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives datapath control lines: RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUOp, plus PC/IR write strobes.
- Handshakes with instruction and data memories, which may stall.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting for a memory ready before FAULT; legal range 1..255.
- CNT_WIDTH, 16: width of the performance counters (optional feature only).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- opcode  in  3  IR[15:13] from datapath.
- Zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data read/write complete this cycle.
- resume  in  1  leave HALT.
- imem_req  out  1  instruction fetch request.
- IRWrite  out  1  latch instruction register.
- PCWrite  out  1  update PC.
- RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc  out  1 each  datapath controls; Branch also selects branch target as PC source.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded.
- halted  out  1  in HALT state.
- fault  out  1  in FAULT state.

Behaviour:
- Reset_n low: state = IDLE immediately (async); all outputs 0.
- IDLE -> FETCH on the first clock after reset release.
- Opcode map: 000 R-type; 001 ADDI; 010 LW; 011 SW; 100 BEQ; 101 ANDI; 110 ORI; 111 HALT.
- Outputs are decoded from the registered state and current opcode (Moore + opcode). Any output not listed for a state is 0.
- FETCH:
  - imem_req=1.
  - On imem_ready: IRWrite=1, PCWrite=1 (PC+1), go to DECODE.
  - Otherwise stay.
- DECODE (1 cycle): opcode 111 -> HALT; else -> EXEC.
- EXEC:
  - R-type: ALUOp=10, RegDst=1; -> WB.
  - ADDI/LW/SW: ALUSrc=1, ALUOp=00. ADDI -> WB; LW/SW -> MEM.
  - ANDI/ORI: ALUSrc=1, ALUOp=10; -> WB.
  - BEQ: ALUOp=01, Branch=1, PCWrite=Zero; -> FETCH.
- MEM:
  - LW: MemRead=1. SW: MemWrite=1. Both held until dmem_ready.
  - On dmem_ready: LW -> WB; SW -> FETCH.
- WB (1 cycle): RegWrite=1; MemToReg=1 for LW only; RegDst=1 for R-type only; -> FETCH.
- Controls are held stable throughout each state, including stall cycles.
- Minimum latencies (ready already high on first request cycle):
  - BEQ: 3 cycles.
  - R-type, immediates, SW: 4 cycles.
  - LW: 5 cycles.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM and increments each cycle ready is low.
  - If ready is still low when wait_cnt == MEM_TIMEOUT-1 -> FAULT.
  - Ready in that same cycle wins: no fault.
- FAULT: fault=1, all other outputs 0; exit only via reset.
- HALT: halted=1, all strobes 0; resume=1 -> FETCH next cycle. resume is ignored in all other states.
- Reset mid-operation (e.g. during MEM stall): outputs drop to 0 asynchronously; no partial RegWrite/MemWrite on release.
- No output is asserted in two conflicting forms: MemRead and MemWrite are never both 1.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[CNT_WIDTH-1:0] and instr_cnt[CNT_WIDTH-1:0], both reset to 0.
  - cycle_cnt increments every cycle outside IDLE/HALT/FAULT.
  - instr_cnt increments on every exit to FETCH from EXEC, MEM or WB (retirement).
  - Both wrap modulo 2^CNT_WIDTH.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then R-type (opcode 000), both readies tied 1 -> IRWrite/PCWrite pulse in cycle 1, RegDst=1 & ALUOp=10 in EXEC, RegWrite=1 in cycle 4, back to FETCH cycle 5.
- LW with dmem_ready low 3 cycles -> MemRead held 4 cycles, then WB with RegWrite=1 & MemToReg=1; total 8 cycles.
- BEQ with Zero=1 then Zero=0 -> PCWrite=1 with Branch=1 in EXEC for first only; 3 cycles each.
- imem_ready held 0, MEM_TIMEOUT=15 -> fault=1 after 15 FETCH cycles; ready rising on cycle 15 -> no fault, DECODE.
- Opcode 111 -> halted=1 after DECODE; resume pulse -> imem_req=1 next cycle; SW issued mid-stall then Reset_n low -> MemWrite drops immediately, IDLE then FETCH after release.
- With CTRL_PERF_CNT_EN: run ADDI, SW, BEQ (readies 1) -> instr_cnt=3, cycle_cnt=11.
